jacobi_grid: RTL and testbench
==============================

# jacobi_grid

Parametrised Jacobi relaxation array of ROWS×COLS fixed-point nodes with an integrated iteration controller, scan load/unload chain and a memory-mapped register interface on the global bus. It replaces the hand-instantiated fixed 4×4 node-plus-control netlist with one generated block. It adds full-precision neighbour summation, a status register with an iteration counter, and optional early termination on convergence.

## Interface
- ROWS, 4: grid rows, ≥3
- COLS, 4: grid columns, ≥3
- WIDTH, 8: node data width, ≤ DATAW
- CWIDTH, 8: iteration counter width, ≤16
- ADDRW, 15: global address width
- DATAW, 32: global data width

- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset; clock Clk
- RD  in  1  bus read strobe
- WR  in  1  bus write strobe
- Addr  in  ADDRW  register address (only bits [1:0] decoded)
- DataIn  in  DATAW  write data
- DataOut  out  DATAW  read data (combinational, driven, never Z)

## Operation
- Node (r,c) has index r*COLS+c. North neighbour is (r-1,c), south (r+1,c), west (r,c-1), east (r,c+1).
- Nodes in row 0, row ROWS-1, column 0 or column COLS-1 are boundary nodes. They never update.
- Interior update: sum of the four neighbours in WIDTH+2 bits, shifted right 2, truncated to WIDTH. All interior nodes update simultaneously from pre-edge values.
- Register map:
  - Addr 0 CTRL: write loads count = DataIn[CWIDTH-1:0], clears converged and iter; read returns count.
  - Addr 1 SCAN: see scan rules below.
  - Addr 2 STATUS (read-only): bit0 busy (count≠0), bit1 converged, bits[16+CWIDTH-1:16] iter.
  - Addr 3 THRESH: write/read WIDTH-bit threshold.
- Unmapped reads, and reads with RD=0, return 0.
- Each edge with busy high performs one update, decrements count, and increments iter (iter saturates).
- Scan rules, active only when not busy:
  - WR to SCAN shifts the chain: node i ← node i+1; node N-1 ← DataIn[WIDTH-1:0].
  - RD to SCAN returns node 0, zero-extended, combinationally, then shifts the chain with 0 into node N-1.
  - N writes load the full grid; N reads unload it in index order.
- SCAN access while busy: read returns node 0, no shift; write is ignored.
- Simultaneous RD and WR: WR takes priority.
- CTRL write while busy: reload count and restart iter at 0. Writing 0 stops after the current edge.

## Timing
- Reset values: all nodes 0, count 0, iter 0, converged 0, THRESH 0. DataOut is 0 while RD=0.
- CTRL write at edge k sets busy after k. The first update happens at edge k+1. Count=N gives exactly N updates; busy falls after edge k+N.
- Scan shift completes at the same edge as the strobe. Read data is valid in the strobe cycle.
- Reset asserted mid-run aborts the run at that edge. All state returns to reset values.

## Configuration
- JACOBI_CONVERGE_EN defined:
  - During each update, compute |new−old| per interior node.
  - If every delta ≤ THRESH, set converged and force count to 0 at the same edge. That update still commits and is counted in iter.
- JACOBI_CONVERGE_EN undefined:
  - No delta logic is built; converged reads 0.
  - THRESH reads 0 and ignores writes.
  - Runs always perform exactly count updates.

## Structure
- Shared package jacobi_pkg holds:
  - register address constants JACOBI_REG_CTRL/SCAN/STATUS/THRESH = 0..3;
  - STATUS bit positions.
- Sub-module jacobi_grid_cell holds one node register: scan mux, update mux, boundary parameter, optional delta compare output. It is instantiated in a generate loop over ROWS×COLS.
- Control, decode and the convergence AND-tree stay in jacobi_grid.

## Test plan
- Reset, then 16 scan writes of 0 except indices 1,2 = 100 (top row). CTRL=1 → after 1 update, node (1,1)=25 and (1,2)=25; 16 scan reads return 0,100,100,0,0,25,25,0…
- All boundary nodes=255, interior 0, CTRL=2 → after the first update, interior = 127 (sum 510; no truncation at WIDTH); after the second, (1,1)=(255+255+127+127)>>2=191.
- CTRL=5 → busy high for exactly 5 cycles; STATUS iter=5 afterwards; count reads 0.
- SCAN write during busy → grid unchanged; RD SCAN during busy returns node 0 with no shift.
- Reset asserted in the 3rd cycle of a CTRL=10 run → all nodes 0, STATUS=0 the next cycle.
- (JACOBI_CONVERGE_EN) all-zero grid, THRESH=0, CTRL=10 → busy falls after 1 update; converged=1; iter=1.

Source files
------------

// File: rtl/jacobi_pkg.sv
// Shared register map and STATUS field positions for the Jacobi relaxation grid.
package jacobi_pkg;
    localparam logic [1:0] JACOBI_REG_CTRL   = 2'd0;
    localparam logic [1:0] JACOBI_REG_SCAN   = 2'd1;
    localparam logic [1:0] JACOBI_REG_STATUS = 2'd2;
    localparam logic [1:0] JACOBI_REG_THRESH = 2'd3;

    localparam int JACOBI_STATUS_BUSY = 0;
    localparam int JACOBI_STATUS_CONV = 1;
    localparam int JACOBI_STATUS_ITER = 16;
endpackage

// File: rtl/jacobi_grid_cell.sv
// One grid node: scan-chain load/shift, four-neighbour average update and,
// when JACOBI_CONVERGE_EN is defined, a |new-old| <= thresh flag.
module jacobi_grid_cell #(
    parameter int WIDTH    = 8,
    parameter bit BOUNDARY = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] shift_in,
    input  logic             upd_en,
    input  logic [WIDTH-1:0] north,
    input  logic [WIDTH-1:0] south,
    input  logic [WIDTH-1:0] west,
    input  logic [WIDTH-1:0] east,
`ifdef JACOBI_CONVERGE_EN
    input  logic [WIDTH-1:0] thresh,
    output logic             delta_ok,
`endif
    output logic [WIDTH-1:0] val
);
    logic [WIDTH-1:0] val_q, val_d, avg;
    logic [WIDTH+1:0] sum;

    // Full-precision sum so four max-valued neighbours never wrap.
    always_comb begin
        sum   = {2'b00, north} + {2'b00, south} + {2'b00, west} + {2'b00, east};
        avg   = WIDTH'(sum >> 2);
        val_d = val_q;
        if (shift_en)
            val_d = shift_in;
        else if (upd_en && !BOUNDARY)
            val_d = avg;
    end

`ifdef JACOBI_CONVERGE_EN
    logic [WIDTH-1:0] delta;
    always_comb begin
        delta    = (avg >= val_q) ? (avg - val_q) : (val_q - avg);
        delta_ok = BOUNDARY || (delta <= thresh);
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) val_q <= '0;
        else       val_q <= val_d;
    end

    assign val = val_q;
endmodule

// File: rtl/jacobi_grid.sv
// ROWSxCOLS Jacobi relaxation array with iteration controller, scan chain and
// register interface. Optional early stop on convergence: JACOBI_CONVERGE_EN.
module jacobi_grid
    import jacobi_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int WIDTH  = 8,
    parameter int CWIDTH = 8,
    parameter int ADDRW  = 15,
    parameter int DATAW  = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             RD,
    input  logic             WR,
    input  logic [ADDRW-1:0] Addr,
    input  logic [DATAW-1:0] DataIn,
    output logic [DATAW-1:0] DataOut
);
    localparam int N = ROWS * COLS;

    logic [N-1:0][WIDTH-1:0] node;
    logic [CWIDTH-1:0]       count_q, count_d, iter_q, iter_d;
    logic                    conv_q, conv_d;
    logic [1:0]              reg_sel;
    logic                    busy, shift_en;
    logic [WIDTH-1:0]        scan_in, thresh_rd;
    logic [DATAW-1:0]        rdata;
    logic                    unused_bits;

    assign reg_sel     = Addr[1:0];
    assign busy        = (count_q != '0);
    assign shift_en    = !busy && (reg_sel == JACOBI_REG_SCAN) && (WR || RD);
    assign scan_in     = WR ? DataIn[WIDTH-1:0] : '0;
    assign unused_bits = ^{Addr[ADDRW-1:2], DataIn};

`ifdef JACOBI_CONVERGE_EN
    logic [WIDTH-1:0] thresh_q, thresh_d;
    logic [N-1:0]     delta_ok;
    logic             all_ok;
    assign all_ok    = &delta_ok;
    assign thresh_rd = thresh_q;
`else
    assign thresh_rd = '0;
`endif

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int I   = r * COLS + c;
            localparam bit B   = (r == 0) || (r == ROWS-1) || (c == 0) || (c == COLS-1);
            // Boundary nodes never update, so their neighbour taps are clamped to self.
            localparam int NI  = (r == 0)      ? I : I - COLS;
            localparam int SI  = (r == ROWS-1) ? I : I + COLS;
            localparam int WI  = (c == 0)      ? I : I - 1;
            localparam int EI  = (c == COLS-1) ? I : I + 1;
            localparam int NXT = (I == N-1)    ? I : I + 1;
            logic [WIDTH-1:0] sin;
            assign sin = (I == N-1) ? scan_in : node[NXT];

            jacobi_grid_cell #(.WIDTH(WIDTH), .BOUNDARY(B)) u_cell (
                .Clk      (Clk),
                .Reset    (Reset),
                .shift_en (shift_en),
                .shift_in (sin),
                .upd_en   (busy),
                .north    (node[NI]),
                .south    (node[SI]),
                .west     (node[WI]),
                .east     (node[EI]),
`ifdef JACOBI_CONVERGE_EN
                .thresh   (thresh_q),
                .delta_ok (delta_ok[I]),
`endif
                .val      (node[I])
            );
        end
    end

    always_comb begin
        count_d = count_q;
        iter_d  = iter_q;
        conv_d  = conv_q;
        if (busy) begin
            count_d = count_q - 1'b1;
            if (iter_q != '1) iter_d = iter_q + 1'b1;
`ifdef JACOBI_CONVERGE_EN
            if (all_ok) begin
                conv_d  = 1'b1;
                count_d = '0;
            end
`endif
        end
        // A CTRL write overrides whatever this edge's update did to the counters.
        if (WR && reg_sel == JACOBI_REG_CTRL) begin
            count_d = DataIn[CWIDTH-1:0];
            iter_d  = '0;
            conv_d  = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (RD) begin
            case (reg_sel)
                JACOBI_REG_CTRL:   rdata[CWIDTH-1:0] = count_q;
                JACOBI_REG_SCAN:   rdata[WIDTH-1:0]  = node[0];
                JACOBI_REG_STATUS: begin
                    rdata[JACOBI_STATUS_BUSY]            = busy;
                    rdata[JACOBI_STATUS_CONV]            = conv_q;
                    rdata[JACOBI_STATUS_ITER +: CWIDTH]  = iter_q;
                end
                default:           rdata[WIDTH-1:0]  = thresh_rd;
            endcase
        end
    end
    assign DataOut = rdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            iter_q  <= iter_d;
            conv_q  <= conv_d;
        end
    end

`ifdef JACOBI_CONVERGE_EN
    always_comb begin
        thresh_d = thresh_q;
        if (WR && reg_sel == JACOBI_REG_THRESH) thresh_d = DataIn[WIDTH-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) thresh_q <= '0;
        else       thresh_q <= thresh_d;
    end
`endif
endmodule

// File: tb/tb_jacobi_grid.sv
// Scoreboard bench for jacobi_grid: reads push expected data, a negedge
// monitor pops and compares whatever the DUT drives on DataOut.
module tb_jacobi_grid;
    logic        Clk = 1'b0;
    logic        Reset, RD, WR;
    logic [14:0] Addr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  pat  [16];
    logic [7:0]  expg [16];

    always #5 Clk = ~Clk;

    jacobi_grid #(.ROWS(4), .COLS(4), .WIDTH(8), .CWIDTH(8), .ADDRW(15), .DATAW(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .RD      (RD),
        .WR      (WR),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .DataOut (DataOut)
    );

    always @(negedge Clk) begin : monitor
        logic [31:0] e;
        string       nm;
        n_tests++;
        if (RD) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got %0h, no expected value queued", DataOut);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (DataOut !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %0h expected %0h", nm, DataOut, e);
                end
            end
        end else if (DataOut !== 32'd0) begin
            n_fail++;
            $display("FAIL idle_dataout: got %0h expected 0", DataOut);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {13'd0, a}; DataIn = d; WR = 1'b1;
        idle(1);
        WR = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        Addr = {13'd0, a}; RD = 1'b1;
        idle(1);
        RD = 1'b0;
    endtask

    task automatic load_pat();
        for (int i = 0; i < 16; i++) wr(2'd1, {24'd0, pat[i]});
    endtask

    task automatic unload(input string nm);
        for (int i = 0; i < 16; i++) rd(2'd1, {24'd0, expg[i]}, $sformatf("%s_node%0d", nm, i));
    endtask

    // Boundary 255, interior (5,6,9,10) set to v.
    task automatic ring(input logic [7:0] v, output logic [7:0] g [16]);
        for (int i = 0; i < 16; i++) g[i] = 8'd255;
        g[5] = v; g[6] = v; g[9] = v; g[10] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RD = 1'b0; WR = 1'b0; Addr = '0; DataIn = '0; Reset = 1'b1;
        idle(2);
        Reset = 1'b0;
        rd(2'd2, 32'd0, "rst_status");
        rd(2'd0, 32'd0, "rst_ctrl");
        rd(2'd3, 32'd0, "rst_thresh");
        rd(2'd1, 32'd0, "rst_node0");

        // Top-row 100s propagate one row down as 25.
        for (int i = 0; i < 16; i++) pat[i] = 8'd0;
        pat[1] = 8'd100; pat[2] = 8'd100;
        load_pat();
        wr(2'd0, 32'd1);
        idle(1);
        rd(2'd2, 32'h0001_0000, "t1_status");
        for (int i = 0; i < 16; i++) expg[i] = 8'd0;
        expg[1] = 8'd100; expg[2] = 8'd100; expg[5] = 8'd25; expg[6] = 8'd25;
        unload("t1");

        // 255 ring: 510>>2 = 127 after one update, 764>>2 = 191 after two.
        ring(8'd0, pat);
        load_pat();
        wr(2'd0, 32'd1);
        idle(1);
        ring(8'd127, expg);
        unload("t2a");
        load_pat();
        wr(2'd0, 32'd2);
        idle(2);
        ring(8'd191, expg);
        unload("t2b");

        // Busy window of exactly five cycles.
        load_pat();
        wr(2'd0, 32'd5);
        for (int i = 0; i < 5; i++) rd(2'd2, (32'(i) << 16) | 32'd1, $sformatf("t3_status%0d", i));
        rd(2'd2, 32'h0005_0000, "t3_status_done");
        rd(2'd0, 32'd0, "t3_count");

        // Scan strobes during busy: write ignored, read does not shift.
        load_pat();
        wr(2'd0, 32'd3);
        wr(2'd1, 32'h0000_00AA);
        rd(2'd1, 32'd255, "t4_busy_rd0");
        rd(2'd1, 32'd255, "t4_busy_rd1");
        rd(2'd2, 32'h0003_0000, "t4_status");
        ring(8'd223, expg);
        unload("t4");

        // Reset in the third cycle of a 10-update run.
        load_pat();
        wr(2'd0, 32'd10);
        idle(2);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        rd(2'd2, 32'd0, "t5_status");
        for (int i = 0; i < 16; i++) expg[i] = 8'd0;
        unload("t5");

        // All-zero grid with THRESH=0.
        wr(2'd3, 32'd7);
`ifdef JACOBI_CONVERGE_EN
        rd(2'd3, 32'd7, "t6_thresh");
`else
        rd(2'd3, 32'd0, "t6_thresh");
`endif
        wr(2'd3, 32'd0);
        wr(2'd0, 32'd10);
        idle(1);
`ifdef JACOBI_CONVERGE_EN
        rd(2'd2, 32'h0001_0002, "t6_status");
`else
        rd(2'd2, 32'h0001_0001, "t6_status");
`endif
        wr(2'd0, 32'd0);
        rd(2'd2, 32'd0, "t6_stopped");

        idle(2);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
